// File: rtl/riscv_pkg.sv
// Shared constants for the RV32I hazard controller: FSM encoding, forward selects, register index width.
// No logic, no latency; imported by the controller and its forwarding unit.
package riscv_pkg;

  localparam int REG_W = 5;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_MDWAIT = 1'b1;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/riscv_fwd_unit.sv
// E-stage operand forwarding selects for both ALU operands; purely combinational, zero latency.
// M results win over W results; x0 is never forwarded.
module riscv_fwd_unit
  import riscv_pkg::*;
#(
  parameter int W = riscv_pkg::REG_W
) (
  input  logic [W-1:0] rs1,
  input  logic [W-1:0] rs2,
  input  logic         reg_write_m,
  input  logic [W-1:0] rd_m,
  input  logic         reg_write_w,
  input  logic [W-1:0] rd_w,
  output logic [1:0]   fwd_a,
  output logic [1:0]   fwd_b
);

  function automatic logic [1:0] sel(input logic [W-1:0] rs,
                                     input logic         wm,
                                     input logic [W-1:0] rdm,
                                     input logic         ww,
                                     input logic [W-1:0] rdw);
    if (wm && (rdm != '0) && (rdm == rs))
      return FWD_M;
    else if (ww && (rdw != '0) && (rdw == rs))
      return FWD_W;
    else
      return FWD_RF;
  endfunction

  always_comb begin
    fwd_a = sel(rs1, reg_write_m, rd_m, reg_write_w, rd_w);
    fwd_b = sel(rs2, reg_write_m, rd_m, reg_write_w, rd_w);
  end

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// 5-stage pipeline hazard control: stalls/flushes, forwarding, mul/div start/done sequencing, stall counter.
// Controls are combinational from state and inputs; only the FSM state and the saturating counter are registered.
module riscv_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int REG_W = riscv_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clr,
  input  logic [REG_W-1:0] i_Rs1D,
  input  logic [REG_W-1:0] i_Rs2D,
  input  logic [REG_W-1:0] i_Rs1E,
  input  logic [REG_W-1:0] i_Rs2E,
  input  logic [REG_W-1:0] i_RdE,
  input  logic             i_ResultSrcE0,
  input  logic             i_PCSrcE,
  input  logic             i_RegWriteM,
  input  logic [REG_W-1:0] i_RdM,
  input  logic             i_RegWriteW,
  input  logic [REG_W-1:0] i_RdW,
  input  logic             i_MdReqE,
  input  logic             i_MdDone,
  output logic             o_StallF,
  output logic             o_StallD,
  output logic             o_StallE,
  output logic             o_FlushD,
  output logic             o_FlushE,
  output logic             o_FlushM,
  output logic [1:0]       o_ForwardAE,
  output logic [1:0]       o_ForwardBE,
  output logic             o_MdStart,
  output logic             o_MdAbort,
  output logic [CNT_W-1:0] o_StallCnt
);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic             load_use;
  logic [CNT_W-1:0] stall_cnt;

  riscv_fwd_unit #(.W(REG_W)) u_fwd (
    .rs1         (i_Rs1E),
    .rs2         (i_Rs2E),
    .reg_write_m (i_RegWriteM),
    .rd_m        (i_RdM),
    .reg_write_w (i_RegWriteW),
    .rd_w        (i_RdW),
    .fwd_a       (o_ForwardAE),
    .fwd_b       (o_ForwardBE)
  );

  assign load_use = i_ResultSrcE0 && (i_RdE != '0) &&
                    ((i_RdE == i_Rs1D) || (i_RdE == i_Rs2D));

  // Priority chain: clear, then mul/div sequencing, then branch, then load-use.
  always_comb begin
    state_nxt = state;
    o_StallF  = 1'b0;
    o_StallD  = 1'b0;
    o_StallE  = 1'b0;
    o_FlushD  = 1'b0;
    o_FlushE  = 1'b0;
    o_FlushM  = 1'b0;
    o_MdStart = 1'b0;
    o_MdAbort = 1'b0;
    if (i_clr) begin
      state_nxt = ST_RUN;
      o_FlushD  = 1'b1;
      o_FlushE  = 1'b1;
      o_FlushM  = 1'b1;
      o_MdAbort = (state == ST_MDWAIT);
    end else if (state == ST_MDWAIT) begin
      if (i_MdDone) begin
        // Stalls drop in the done cycle so E advances on the next edge without reissue.
        state_nxt = ST_RUN;
      end else begin
        o_StallF = 1'b1;
        o_StallD = 1'b1;
        o_StallE = 1'b1;
        o_FlushM = 1'b1;
      end
    end else if (i_MdReqE) begin
      state_nxt = ST_MDWAIT;
      o_MdStart = 1'b1;
      o_StallF  = 1'b1;
      o_StallD  = 1'b1;
      o_StallE  = 1'b1;
      o_FlushM  = 1'b1;
    end else if (i_PCSrcE) begin
      o_FlushD = 1'b1;
      o_FlushE = 1'b1;
    end else if (load_use) begin
      o_StallF = 1'b1;
      o_StallD = 1'b1;
      o_FlushE = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= ST_RUN;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (o_StallF && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign o_StallCnt = stall_cnt;

endmodule
